// File: rtl/stego_msg_scheduler.sv
// Raster tracker that hands NUM_CH message bits to the encoders per 8x8 block.
// Bits are fetched on a block's first row and replayed from a column buffer.
module stego_msg_scheduler #(
  parameter int FRAME_WIDTH  = 1920,
  parameter int FRAME_HEIGHT = 1080,
  parameter int NUM_CH       = 3,
  parameter int MSG_W        = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_valid,
  input  logic              pix_sof,
  input  logic              pix_eol,
  input  logic              embed_en,
  input  logic [MSG_W-1:0]  msg_tdata,
  input  logic              msg_tvalid,
  output logic              msg_tready,
  output logic [NUM_CH-1:0] msg_bits,
  output logic              msg_en,
  output logic              frame_done,
  output logic              underrun,
  output logic              sof_err,
  output logic              eol_err
);

  localparam int BPW  = MSG_W / NUM_CH;
  localparam int NBLK = FRAME_WIDTH / 8;
  localparam int CW   = $clog2(FRAME_WIDTH);
  localparam int RW   = $clog2(FRAME_HEIGHT);
  localparam int BLW  = $clog2(BPW + 1);
  localparam int BCW  = CW - 3;

  localparam logic [CW-1:0]  COL_MAX = CW'(FRAME_WIDTH - 1);
  localparam logic [RW-1:0]  ROW_MAX = RW'(FRAME_HEIGHT - 1);
  localparam logic [BLW-1:0] BPW_L   = BLW'(BPW);

  typedef enum logic [1:0] {
    IDLE,
    EMBED,
    PASS
  } state_t;

  state_t              state;
  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic [MSG_W-1:0]    word;
  logic [BLW-1:0]      blocks_left;
  logic [NBLK-1:0]     bk_vld;
  logic [NUM_CH-1:0]   bk_bits [NBLK];

  logic                sof_hit;
  logic                active;
  logic [CW-1:0]       pos_col;
  logic [RW-1:0]       pos_row;
  logic [BCW-1:0]      blk_col;
  logic                col_end;
  logic                last_pix;
  logic                embed;
  logic                fetch;
  logic                do_fetch;
  logic                empty;
  logic                take;
  logic                have;
  logic [NUM_CH-1:0]   group;

  // An SOF pixel is always treated as (0,0) and selects the mode itself
  assign sof_hit  = pix_valid && pix_sof;
  assign active   = pix_valid && (pix_sof || state != IDLE);
  assign pos_col  = pix_sof ? '0 : col;
  assign pos_row  = pix_sof ? '0 : row;
  assign blk_col  = pos_col[CW-1:3];
  assign col_end  = pos_col == COL_MAX;
  assign last_pix = col_end && pos_row == ROW_MAX;
  assign embed    = pix_sof ? embed_en : (state == EMBED);
  assign fetch    = embed && pos_col[2:0] == 3'd0
                    && pos_row[2:0] == 3'd0;
  assign do_fetch = pix_valid && fetch;
  assign empty    = blocks_left == '0;
  assign take     = msg_tvalid && msg_tready;
  assign have     = !empty || msg_tvalid;
  assign group    = empty ? msg_tdata[NUM_CH-1:0]
                          : word[NUM_CH-1:0];

  // Zero-latency outputs; reset forces them low
  always_comb begin
    msg_bits = '0;
    msg_en   = 1'b0;
    if (!reset) begin
      if (fetch) begin
        if (have) begin
          msg_bits = group;
          msg_en   = 1'b1;
        end
      end else if (embed && bk_vld[blk_col]) begin
        msg_bits = bk_bits[blk_col];
        msg_en   = 1'b1;
      end
    end
  end

  assign msg_tready = !reset && empty;
  assign frame_done = !reset && active && last_pix;
  assign sof_err    = !reset && sof_hit && state != IDLE
                      && (col != '0 || row != '0);
  assign eol_err    = !reset && active && (pix_eol != col_end);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      word        <= '0;
      blocks_left <= '0;
      bk_vld      <= '0;
      underrun    <= 1'b0;
    end else begin
      if (sof_hit) begin
        state <= embed_en ? EMBED : PASS;
      end else if (active && last_pix) begin
        state <= IDLE;
      end

      if (active) begin
        if (col_end) begin
          col <= '0;
          row <= (pos_row == ROW_MAX) ? '0 : pos_row + RW'(1);
        end else begin
          col <= pos_col + CW'(1);
          row <= pos_row;
        end
      end

      // A word taken on a block start gives up group 0 immediately
      if (take) begin
        if (do_fetch) begin
          word        <= msg_tdata >> NUM_CH;
          blocks_left <= BPW_L - BLW'(1);
        end else begin
          word        <= msg_tdata;
          blocks_left <= BPW_L;
        end
      end else if (do_fetch && !empty) begin
        word        <= word >> NUM_CH;
        blocks_left <= blocks_left - BLW'(1);
      end

      if (do_fetch) begin
        bk_vld[blk_col]  <= have;
        bk_bits[blk_col] <= group;
      end

      if (do_fetch && !have) begin
        underrun <= 1'b1;
      end else if (sof_hit) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stego_msg_scheduler.sv
// Bench for stego_msg_scheduler at 16x16, 3 channels, 6-bit words.
// A group-queue model predicts every output; directed checks cover corners.
module tb_stego_msg_scheduler;

  logic       clk;
  logic       reset;
  logic       pix_valid;
  logic       pix_sof;
  logic       pix_eol;
  logic       embed_en;
  logic [5:0] msg_tdata;
  logic       msg_tvalid;
  logic       msg_tready;
  logic [2:0] msg_bits;
  logic       msg_en;
  logic       frame_done;
  logic       underrun;
  logic       sof_err;
  logic       eol_err;

  stego_msg_scheduler #(
    .FRAME_WIDTH(16),
    .FRAME_HEIGHT(16),
    .NUM_CH(3),
    .MSG_W(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pix_valid(pix_valid),
    .pix_sof(pix_sof),
    .pix_eol(pix_eol),
    .embed_en(embed_en),
    .msg_tdata(msg_tdata),
    .msg_tvalid(msg_tvalid),
    .msg_tready(msg_tready),
    .msg_bits(msg_bits),
    .msg_en(msg_en),
    .frame_done(frame_done),
    .underrun(underrun),
    .sof_err(sof_err),
    .eol_err(eol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: frame mode, position, queue of pending bit groups
  int         m_mode;
  int         m_x;
  int         m_y;
  logic [2:0] m_groups [$];
  bit         m_bv [2];
  logic [2:0] m_bb [2];
  bit         m_under;
  logic [5:0] msgq [$];

  logic [2:0] o_bits;
  logic       o_en;
  logic       o_rdy;
  logic       o_fd;
  logic       o_serr;
  logic       o_eerr;
  logic       o_und;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    m_mode  = 0;
    m_x     = 0;
    m_y     = 0;
    m_groups.delete();
    m_bv[0] = 0;
    m_bv[1] = 0;
    m_bb[0] = 3'd0;
    m_bb[1] = 3'd0;
    m_under = 0;
    msgq.delete();
  endtask

  task automatic step(input bit pv, input bit sof, input bit eol,
                      input bit en, input bit tvg);
    bit         tv;
    logic [5:0] td;
    int         x;
    int         y;
    bit         live;
    bit         emb;
    bit         fet;
    bit         rdy;
    bit         have;
    logic [2:0] grp;
    bit         e_en;
    logic [2:0] e_bits;
    tv = tvg && msgq.size() > 0;
    td = tv ? msgq[0] : 6'd0;
    pix_valid  = pv;
    pix_sof    = sof;
    pix_eol    = eol;
    embed_en   = en;
    msg_tvalid = tv;
    msg_tdata  = td;
    @(negedge clk);
    o_bits = msg_bits;
    o_en   = msg_en;
    o_rdy  = msg_tready;
    o_fd   = frame_done;
    o_serr = sof_err;
    o_eerr = eol_err;
    o_und  = underrun;
    x    = sof ? 0 : m_x;
    y    = sof ? 0 : m_y;
    live = pv && (sof || m_mode != 0);
    emb  = sof ? en : (m_mode == 1);
    fet  = emb && (x % 8 == 0) && (y % 8 == 0);
    rdy  = m_groups.size() == 0;
    have = !rdy || tv;
    grp  = rdy ? td[2:0] : m_groups[0];
    if (fet) begin
      e_en   = have;
      e_bits = have ? grp : 3'd0;
    end else if (emb) begin
      e_en   = m_bv[x / 8];
      e_bits = e_en ? m_bb[x / 8] : 3'd0;
    end else begin
      e_en   = 0;
      e_bits = 3'd0;
    end
    if (pv) begin
      chk("msg_en", 32'(o_en), 32'(e_en));
      chk("msg_bits", 32'(o_bits), 32'(e_bits));
    end
    chk("msg_tready", 32'(o_rdy), 32'(rdy));
    chk("frame_done", 32'(o_fd), 32'(live && x == 15 && y == 15));
    chk("sof_err", 32'(o_serr),
        32'(pv && sof && m_mode != 0 && (m_x != 0 || m_y != 0)));
    chk("eol_err", 32'(o_eerr), 32'(live && (eol != (x == 15))));
    chk("underrun", 32'(o_und), 32'(m_under));
    if (rdy && tv) begin
      void'(msgq.pop_front());
      m_groups.push_back(td[2:0]);
      m_groups.push_back(td[5:3]);
    end
    if (pv && sof) m_under = 0;
    if (pv && fet) begin
      if (m_groups.size() > 0) begin
        m_bv[x / 8] = 1;
        m_bb[x / 8] = m_groups.pop_front();
      end else begin
        m_bv[x / 8] = 0;
        m_under     = 1;
      end
    end
    if (live) begin
      if (x == 15) begin
        m_x = 0;
        m_y = (y == 15) ? 0 : y + 1;
      end else begin
        m_x = x + 1;
        m_y = y;
      end
    end
    if (pv && sof) m_mode = en ? 1 : 2;
    else if (live && x == 15 && y == 15) m_mode = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    pix_valid  = 1'b0;
    pix_sof    = 1'b0;
    pix_eol    = 1'b0;
    embed_en   = 1'b0;
    msg_tvalid = 1'b0;
    msg_tdata  = 6'd0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_msg_tready", 32'(msg_tready), 0);
    chk("rst_msg_bits", 32'(msg_bits), 0);
    chk("rst_msg_en", 32'(msg_en), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_sof_err", 32'(sof_err), 0);
    chk("rst_eol_err", 32'(eol_err), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic run_pix(input int n, input bit en);
    for (int i = 0; i < n; i++) begin
      step(1, m_mode == 0, (m_mode == 0 ? 0 : m_x) == 15, en, 1);
    end
  endtask

  typedef struct {
    bit         pv;
    bit         sof;
    bit         eol;
    bit         tv;
    logic [5:0] td;
    logic [2:0] bits;
    bit         men;
    bit         rdy;
    bit         fd;
    bit         serr;
    bit         eerr;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int         r;
    int         c;
    logic [2:0] exp3;
    bit         started;
    bit         done;
    bit         fen;
    bit         pv;
    bit         sof;
    bit         eol;

    tbl[0] = '{0, 0, 0, 0, 6'd0, 3'd0, 0, 1, 0, 0, 0};
    tbl[1] = '{1, 0, 0, 0, 6'd0, 3'd0, 0, 1, 0, 0, 0};
    tbl[2] = '{1, 1, 0, 1, 6'b010_111, 3'b111, 1, 1, 0, 0, 0};
    tbl[3] = '{1, 0, 0, 0, 6'd0, 3'b111, 1, 0, 0, 0, 0};
    tbl[4] = '{0, 0, 0, 0, 6'd0, 3'd0, 0, 0, 0, 0, 0};
    tbl[5] = '{1, 0, 1, 0, 6'd0, 3'b111, 1, 0, 0, 0, 1};
    tbl[6] = '{1, 1, 0, 0, 6'd0, 3'b010, 1, 0, 0, 1, 0};
    tbl[7] = '{1, 0, 0, 0, 6'd0, 3'b010, 1, 1, 0, 0, 0};

    reset = 1'b1;
    model_clear();
    do_reset();

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].tv) msgq.push_back(tbl[i].td);
      step(tbl[i].pv, tbl[i].sof, tbl[i].eol, 1, tbl[i].tv);
      if (tbl[i].pv) begin
        chk($sformatf("tbl%0d_en", i), 32'(o_en), 32'(tbl[i].men));
        chk($sformatf("tbl%0d_bits", i), 32'(o_bits), 32'(tbl[i].bits));
      end
      chk($sformatf("tbl%0d_rdy", i), 32'(o_rdy), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_fd", i), 32'(o_fd), 32'(tbl[i].fd));
      chk($sformatf("tbl%0d_serr", i), 32'(o_serr), 32'(tbl[i].serr));
      chk($sformatf("tbl%0d_eerr", i), 32'(o_eerr), 32'(tbl[i].eerr));
      chk($sformatf("tbl%0d_und", i), 32'(o_und), 0);
    end

    // Two preloaded words spread across the four blocks
    do_reset();
    msgq.push_back(6'b101_011);
    msgq.push_back(6'b110_001);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 256; i++) begin
      r = m_y;
      c = m_x;
      step(1, i == 0, c == 15, 1, 1);
      if (r < 8) exp3 = (c < 8) ? 3'b011 : 3'b101;
      else exp3 = (c < 8) ? 3'b001 : 3'b110;
      chk("t1_en", 32'(o_en), 1);
      chk("t1_bits", 32'(o_bits), 32'(exp3));
      if (i == 255) chk("t1_done", 32'(o_fd), 1);
    end

    // Pass-through frame leaves a held word untouched
    do_reset();
    msgq.push_back(6'b111_111);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 256; i++) begin
      step(1, i == 0, m_x == 15, 0, 1);
      chk("t2_en", 32'(o_en), 0);
      chk("t2_bits", 32'(o_bits), 0);
      chk("t2_rdy", 32'(o_rdy), 0);
    end

    // Late word: first block underruns, bypass feeds the second
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1, i == 0, 0, 1, 1);
      if (i == 0) chk("t3_blk0_en", 32'(o_en), 0);
    end
    msgq.push_back(6'b011_101);
    step(1, 0, 0, 1, 1);
    chk("t3_bypass_en", 32'(o_en), 1);
    chk("t3_bypass_bits", 32'(o_bits), 32'(3'b101));
    chk("t3_underrun", 32'(o_und), 1);
    run_pix(10, 1);

    // SOF reissued mid-frame restarts at block (0,0)
    do_reset();
    msgq.push_back(6'b001_010);
    msgq.push_back(6'b100_111);
    msgq.push_back(6'b000_110);
    run_pix(5 * 16 + 3, 1);
    step(1, 1, 0, 1, 1);
    chk("t4_sof_err", 32'(o_serr), 1);
    chk("t4_restart_bits", 32'(o_bits), 32'(3'b111));
    chk("t4_restart_en", 32'(o_en), 1);
    run_pix(12, 1);

    // EOL misplaced, then missing; position keeps counting
    do_reset();
    for (int cc = 0; cc < 16; cc++) begin
      step(1, cc == 0, cc == 9, 0, 1);
      if (cc == 9) chk("t5_early_eol", 32'(o_eerr), 1);
      if (cc == 15) chk("t5_missing_eol", 32'(o_eerr), 1);
    end
    for (int cc = 0; cc < 16; cc++) begin
      step(1, 0, cc == 15, 0, 1);
      if (cc == 15) chk("t5_resync_free", 32'(o_eerr), 0);
    end

    // Reset in the middle of row 1, then a clean frame
    do_reset();
    msgq.push_back(6'b110_011);
    msgq.push_back(6'b010_010);
    run_pix(16 + 4, 1);
    do_reset();
    msgq.push_back(6'b101_100);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 1);
    step(1, 1, 0, 1, 1);
    chk("t6_bits", 32'(o_bits), 32'(3'b100));
    chk("t6_en", 32'(o_en), 1);
    run_pix(255, 1);

    // Randomised frames against the model
    for (int f = 0; f < 4; f++) begin
      fen     = 1'($urandom_range(0, 1));
      started = 0;
      done    = 0;
      for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
        if (msgq.size() < 2 && $urandom_range(0, 3) == 0)
          msgq.push_back(6'($urandom));
        pv  = $urandom_range(0, 3) != 0;
        sof = pv && (m_mode == 0 || $urandom_range(0, 399) == 0);
        eol = (((sof ? 0 : m_x) == 15) != ($urandom_range(0, 63) == 0));
        step(pv, sof, eol, fen, $urandom_range(0, 2) != 0);
        if (m_mode != 0) started = 1;
        else if (started) done = 1;
      end
      chk("rand_frame_complete", 32'(done), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
